// File: rtl/pd_framer.sv
// PCIe 8b/10b framing scanner: walks each registered beat byte 0 upward and emits
// registered per-byte start/end/TLP/DLLP/nullify masks, with framing state carried across beats.
module pd_framer #(
    parameter int unsigned LANES = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*LANES-1:0]   data_in,
    input  logic [LANES-1:0]     DK_in,
    input  logic                 hld_in,
    output logic [8*LANES-1:0]   data_out,
    output logic [LANES-1:0]     DK_out,
    output logic [LANES-1:0]     sop_mask,
    output logic [LANES-1:0]     eop_mask,
    output logic [LANES-1:0]     tlp_mask,
    output logic [LANES-1:0]     dllp_mask,
    output logic [LANES-1:0]     nullify_mask,
    output logic                 frm_err,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 hld_out
);

    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TLP  = 2'd1,
        S_DLLP = 2'd2
    } frm_state_t;

    frm_state_t       state;
    frm_state_t       state_nxt;
    frm_state_t       scan_st;
    logic [7:0]       scan_byte;
    logic             scan_k;
    logic [LANES-1:0] sop_nxt;
    logic [LANES-1:0] eop_nxt;
    logic [LANES-1:0] tlp_nxt;
    logic [LANES-1:0] dllp_nxt;
    logic [LANES-1:0] null_nxt;
    logic             err_nxt;

    assign hld_out = hld_in;

    // Framing state register; a held edge leaves it untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else if (!hld_in) begin
            state <= state_nxt;
        end
    end

    // Sequential byte walk; scan_st is the framing state seen by each successive byte.
    always_comb begin
        sop_nxt   = '0;
        eop_nxt   = '0;
        tlp_nxt   = '0;
        dllp_nxt  = '0;
        null_nxt  = '0;
        err_nxt   = 1'b0;
        scan_st   = state;
        scan_byte = '0;
        scan_k    = 1'b0;
        for (int i = 0; i < int'(LANES); i++) begin
            scan_byte = data_in[8*i +: 8];
            scan_k    = DK_in[i];
            if (!scan_k) begin
                if (scan_st == S_TLP) begin
                    tlp_nxt[i] = 1'b1;
                end else if (scan_st == S_DLLP) begin
                    dllp_nxt[i] = 1'b1;
                end
            end else if (scan_byte == K_STP) begin
                if (scan_st != S_IDLE) err_nxt = 1'b1;
                sop_nxt[i] = 1'b1;
                tlp_nxt[i] = 1'b1;
                scan_st    = S_TLP;
            end else if (scan_byte == K_SDP) begin
                if (scan_st != S_IDLE) err_nxt = 1'b1;
                sop_nxt[i]  = 1'b1;
                dllp_nxt[i] = 1'b1;
                scan_st     = S_DLLP;
            end else if (scan_byte == K_END || scan_byte == K_EDB) begin
                case (scan_st)
                    S_TLP: begin
                        eop_nxt[i]  = 1'b1;
                        tlp_nxt[i]  = 1'b1;
                        null_nxt[i] = (scan_byte == K_EDB);
                    end
                    S_DLLP: begin
                        eop_nxt[i]  = 1'b1;
                        dllp_nxt[i] = 1'b1;
                        if (scan_byte == K_EDB) err_nxt = 1'b1;
                    end
                    default: err_nxt = 1'b1;
                endcase
                scan_st = S_IDLE;
            end else if (scan_st != S_IDLE) begin
                err_nxt = 1'b1;
                scan_st = S_IDLE;
            end
        end
        state_nxt = scan_st;
    end

    // Output registers, all frozen together while held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out     <= '0;
            DK_out       <= '0;
            sop_mask     <= '0;
            eop_mask     <= '0;
            tlp_mask     <= '0;
            dllp_mask    <= '0;
            nullify_mask <= '0;
            frm_err      <= 1'b0;
            err_cnt      <= '0;
        end else if (!hld_in) begin
            data_out     <= data_in;
            DK_out       <= DK_in;
            sop_mask     <= sop_nxt;
            eop_mask     <= eop_nxt;
            tlp_mask     <= tlp_nxt;
            dllp_mask    <= dllp_nxt;
            nullify_mask <= null_nxt;
            frm_err      <= err_nxt;
            if (err_nxt && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pd_framer.sv
// Directed bench for pd_framer: a full-width instance plus a CNT_W=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_pd_framer;

    localparam int unsigned LANES = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic [8*LANES-1:0] data_in;
    logic [LANES-1:0]   DK_in;
    logic               hld_in;

    logic [8*LANES-1:0] data_out, data_out2;
    logic [LANES-1:0]   DK_out, DK_out2;
    logic [LANES-1:0]   sop_mask, eop_mask, tlp_mask, dllp_mask, nullify_mask;
    logic [LANES-1:0]   sop_mask2, eop_mask2, tlp_mask2, dllp_mask2, nullify_mask2;
    logic               frm_err, frm_err2;
    logic [15:0]        err_cnt;
    logic [1:0]         err_cnt2;
    logic               hld_out, hld_out2;

    logic [8*LANES-1:0] exp_data;
    logic [LANES-1:0]   exp_dk;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pd_framer #(.LANES(LANES), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .DK_in(DK_in), .hld_in(hld_in),
        .data_out(data_out), .DK_out(DK_out), .sop_mask(sop_mask), .eop_mask(eop_mask),
        .tlp_mask(tlp_mask), .dllp_mask(dllp_mask), .nullify_mask(nullify_mask),
        .frm_err(frm_err), .err_cnt(err_cnt), .hld_out(hld_out)
    );

    pd_framer #(.LANES(LANES), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .data_in(data_in), .DK_in(DK_in), .hld_in(hld_in),
        .data_out(data_out2), .DK_out(DK_out2), .sop_mask(sop_mask2), .eop_mask(eop_mask2),
        .tlp_mask(tlp_mask2), .dllp_mask(dllp_mask2), .nullify_mask(nullify_mask2),
        .frm_err(frm_err2), .err_cnt(err_cnt2), .hld_out(hld_out2)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every byte an idle K symbol (other K: harmless in IDLE, error inside a packet).
    task automatic clr_beat();
        data_in = {LANES{8'h7C}};
        DK_in   = '1;
    endtask

    task automatic set_k(input int i, input logic [7:0] b);
        data_in[8*i +: 8] = b;
        DK_in[i]          = 1'b1;
    endtask

    task automatic set_d(input int i, input logic [7:0] b);
        data_in[8*i +: 8] = b;
        DK_in[i]          = 1'b0;
    endtask

    task automatic chk_masks(input string tag, input logic [63:0] sop, input logic [63:0] eop,
                             input logic [63:0] tlp, input logic [63:0] dllp,
                             input logic [63:0] nul, input logic err);
        chk({tag, "_sop"},  512'(sop_mask),     512'(sop));
        chk({tag, "_eop"},  512'(eop_mask),     512'(eop));
        chk({tag, "_tlp"},  512'(tlp_mask),     512'(tlp));
        chk({tag, "_dllp"}, 512'(dllp_mask),    512'(dllp));
        chk({tag, "_null"}, 512'(nullify_mask), 512'(nul));
        chk({tag, "_err"},  512'(frm_err),      512'(err));
    endtask

    initial begin
        rst    = 1'b0;
        hld_in = 1'b0;
        clr_beat();
        #12;
        chk_masks("reset", 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);
        chk("reset_cnt",  512'(err_cnt), 512'(0));
        chk("reset_data", data_out, 512'(0));
        chk("reset_hld",  512'(hld_out), 512'(0));
        #5 rst = 1'b1;

        // Single-beat TLP; data bytes equal to 0xFD/0xFB must not frame.
        step();
        clr_beat();
        set_k(0, 8'hFB);
        for (int i = 1; i <= 14; i++) set_d(i, 8'(8'hA0 + i));
        set_d(7, 8'hFD);
        set_d(8, 8'hFB);
        set_k(15, 8'hFD);
        exp_data = data_in;
        exp_dk   = DK_in;
        step();
        chk_masks("tlp1", 64'h1, 64'h8000, 64'hFFFF, 64'h0, 64'h0, 1'b0);
        chk("tlp1_data", data_out, exp_data);
        chk("tlp1_dk",   512'(DK_out), 512'(exp_dk));
        chk("tlp1_cnt",  512'(err_cnt), 512'(0));

        // DLLP spanning two beats.
        clr_beat();
        set_k(60, 8'h5C);
        for (int i = 61; i <= 63; i++) set_d(i, 8'(8'h10 + i));
        step();
        chk_masks("spanA", 64'h1000_0000_0000_0000, 64'h0, 64'h0,
                  64'hF000_0000_0000_0000, 64'h0, 1'b0);
        clr_beat();
        for (int i = 0; i <= 3; i++) set_d(i, 8'(8'h30 + i));
        set_k(4, 8'hFD);
        step();
        chk_masks("spanB", 64'h0, 64'h10, 64'h0, 64'h1F, 64'h0, 1'b0);

        // Nullified TLP.
        clr_beat();
        set_k(0, 8'hFB);
        for (int i = 1; i <= 4; i++) set_d(i, 8'(i));
        set_k(5, 8'hFE);
        step();
        chk_masks("null", 64'h1, 64'h20, 64'h3F, 64'h0, 64'h20, 1'b0);

        // DLLP closed by EDB is an error.
        clr_beat();
        set_k(0, 8'h5C);
        set_d(1, 8'h11);
        set_d(2, 8'h22);
        set_k(3, 8'hFE);
        step();
        chk_masks("dllp_edb", 64'h1, 64'h8, 64'h0, 64'hF, 64'h0, 1'b1);
        chk("dllp_edb_cnt", 512'(err_cnt), 512'(1));

        // New start inside an open TLP.
        clr_beat();
        set_k(0, 8'hFB);
        set_d(1, 8'h01);
        set_d(2, 8'h02);
        set_k(3, 8'h5C);
        for (int i = 4; i <= 8; i++) set_d(i, 8'(i));
        set_k(9, 8'hFD);
        step();
        chk_masks("nest", 64'h9, 64'h200, 64'h7, 64'h3F8, 64'h0, 1'b1);
        chk("nest_cnt", 512'(err_cnt), 512'(2));

        // Open a TLP at the end of a beat, then hold.
        clr_beat();
        set_k(62, 8'hFB);
        set_d(63, 8'h55);
        exp_data = data_in;
        step();
        chk_masks("pre_hold", 64'h4000_0000_0000_0000, 64'h0, 64'hC000_0000_0000_0000,
                  64'h0, 64'h0, 1'b0);
        hld_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            clr_beat();
            set_k(c, 8'hFD);
            set_k(c + 1, 8'h5C);
            step();
            chk_masks("hold", 64'h4000_0000_0000_0000, 64'h0, 64'hC000_0000_0000_0000,
                      64'h0, 64'h0, 1'b0);
            chk("hold_data", data_out, exp_data);
            chk("hold_cnt",  512'(err_cnt), 512'(2));
            chk("hold_out",  512'(hld_out), 512'(1));
        end
        hld_in = 1'b0;
        clr_beat();
        for (int i = 0; i <= 2; i++) set_d(i, 8'(8'h70 + i));
        set_k(3, 8'hFD);
        step();
        chk_masks("post_hold", 64'h0, 64'h8, 64'hF, 64'h0, 64'h0, 1'b0);
        chk("post_hold_cnt", 512'(err_cnt), 512'(2));
        chk("post_hold_out", 512'(hld_out), 512'(0));

        // Asynchronous reset mid-TLP.
        clr_beat();
        set_k(63, 8'hFB);
        step();
        chk("pre_rst_sop", 512'(sop_mask), 512'(64'h8000_0000_0000_0000));
        #2 rst = 1'b0;
        #1;
        chk_masks("rst_mid", 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);
        chk("rst_mid_cnt",  512'(err_cnt), 512'(0));
        chk("rst_mid_data", data_out, 512'(0));
        hld_in = 1'b1;
        #1;
        chk("rst_hld_out", 512'(hld_out), 512'(1));
        hld_in = 1'b0;
        #1 rst = 1'b1;
        clr_beat();
        for (int i = 0; i <= 3; i++) set_d(i, 8'(8'h40 + i));
        step();
        chk_masks("after_rst", 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);

        // Five error beats: END with no open packet.
        for (int c = 1; c <= 5; c++) begin
            clr_beat();
            set_k(0, 8'hFD);
            step();
            chk("sat_err", 512'(frm_err), 512'(1));
            chk("sat_cnt16", 512'(err_cnt), 512'(c));
            chk("sat_cnt2", 512'(err_cnt2), 512'((c > 3) ? 3 : c));
        end
        clr_beat();
        step();
        chk("sat_clear_err", 512'(frm_err), 512'(0));
        chk("sat_final2", 512'(err_cnt2), 512'(3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pd_framer.md
Name: pd_framer

Overview:
- Downstream neighbour of the PD hold register; consumes its registered 512-bit beat (64 bytes) and 64-bit per-byte D/K flags.
- Scans each beat byte-by-byte (byte 0 earliest) for PCIe 8b/10b framing symbols and emits registered per-byte masks: start, end, TLP, DLLP and nullify.
- Framing state carries across beats so packets may span beats.
- Feeds the TLP/DLLP extraction stage.

Parameters:
- LANES, 64, bytes per beat; data width = 8*LANES, DK width = LANES.
- CNT_W, 16, width of the saturating framing-error counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- data_in  in  8*LANES  beat from PD register; byte i = data_in[8i+7:8i]
- DK_in  in  LANES  1 = byte i is a K symbol
- hld_in  in  1  1 = stall; no state or output-register update
- data_out  out  8*LANES  data_in delayed one beat
- DK_out  out  LANES  DK_in delayed one beat
- sop_mask  out  LANES  byte is STP or SDP that opens a packet
- eop_mask  out  LANES  byte is END or EDB closing a packet
- tlp_mask  out  LANES  byte belongs to a TLP (STP through END/EDB inclusive)
- dllp_mask  out  LANES  byte belongs to a DLLP (SDP through END inclusive)
- nullify_mask  out  LANES  byte is the EDB of a nullified TLP
- frm_err  out  1  pulse: at least one framing error in the registered beat
- err_cnt  out  CNT_W  saturating count of beats with frm_err
- hld_out  out  1  combinational copy of hld_in

Behaviour:
- Symbols (K only; the same byte with DK=0 is ordinary data): STP=0xFB, SDP=0x5C, END=0xFD, EDB=0xFE. Any other K byte (COM 0xBC, SKP 0x1C, PAD 0xF7, IDL 0x7C, …) is "other K".
- Framing state s ∈ {IDLE, TLP, DLLP}, one register; beat scan starts from registered s.
- Per byte, in order 0..LANES-1:
  - IDLE:
    - STP → sop, tlp, s=TLP.
    - SDP → sop, dllp, s=DLLP.
    - END/EDB → error, no mask bits, stay IDLE.
    - Data byte or other K → nothing.
  - TLP:
    - Data byte → tlp.
    - END → eop, tlp, s=IDLE.
    - EDB → eop, tlp, nullify, s=IDLE.
  - DLLP:
    - Data byte → dllp.
    - END → eop, dllp, s=IDLE.
    - EDB → error, eop, dllp, s=IDLE.
  - TLP/DLLP, STP or SDP: error; the open packet is abandoned without eop; the byte opens a new packet as in IDLE.
  - TLP/DLLP, other K: error, no mask bits, s=IDLE.
- Masks for a byte are mutually consistent: tlp and dllp are never both set; nullify ⇒ eop ∧ tlp.
- Latency: one clock. Masks, data_out, DK_out and frm_err for a beat appear together on the edge after capture.
- Hold, when hld_in=1 at the edge:
  - All registers (outputs, s, err_cnt) keep their values.
  - data_in is ignored that cycle.
  - Hold has no beat count limit.
- err_cnt: +1 on each non-held edge whose beat had an error; saturates at 2^CNT_W-1, never wraps.
- Reset (rst=0, async): all outputs 0, s=IDLE, err_cnt=0; takes effect immediately, mid-packet included. The first beat after release is scanned from IDLE.
- hld_out is unaffected by reset.

Test Plan:
- Single-beat TLP:
  - Stimulus: DK[0]=1 data byte0=0xFB, bytes 1–14 data, DK[15]=1 byte15=0xFD, rest DK=1 0x7C.
  - Response next cycle: sop_mask=0x1, eop_mask=0x8000, tlp_mask=0xFFFF, dllp_mask=0, frm_err=0.
- Spanning DLLP:
  - Stimulus: beat A SDP at byte 60, bytes 61–63 data; beat B bytes 0–3 data, END at byte 4.
  - Response A: sop bit60, dllp_mask=0xF000_0000_0000_0000. Response B: dllp_mask=0x1F, eop bit4.
- Nullified TLP and error:
  - Stimulus: STP byte0, EDB byte5 → eop bit5, nullify bit5, tlp_mask=0x3F. Separately SDP byte0, EDB byte3 → frm_err=1, err_cnt increments.
- Nested start:
  - Stimulus: STP byte0, data 1–2, SDP byte3, END byte9.
  - Response: sop=0x9, tlp_mask=0x7, dllp_mask=0x3F8, eop=0x200, frm_err=1.
- Hold:
  - Stimulus: hld_in=1 for 3 cycles with varying data_in mid-TLP.
  - Response: outputs and err_cnt frozen, hld_out=1; after release, scan continues in TLP state.
- Reset and saturation:
  - Stimulus: assert rst mid-TLP (between clock edges).
  - Response: outputs 0 immediately; next data bytes are not tlp.
  - With CNT_W=2, 5 erroneous beats → err_cnt=3.
